// File: rtl/mips_irq_ctrl.sv
// mips_irq_ctrl: multi-channel interrupt controller in front of the MIPS core.
// Edge/level latching, mask, fixed priority with nesting, ir/eret tracking.
module mips_irq_ctrl #(
  parameter int unsigned NUM_IRQ         = 8,
  parameter logic [31:0] VEC_BASE        = 32'h0000_0100,
  parameter int unsigned VEC_STRIDE_LOG2 = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic               cfg_wen,
  input  logic [1:0]         cfg_addr,
  input  logic [31:0]        cfg_din,
  output logic [31:0]        cfg_dout,
  output logic               interrupt,
  output logic [4:0]         irq_id,
  output logic [31:0]        irq_vector,
  input  logic               ir,
  input  logic               eret
);

  typedef logic [NUM_IRQ-1:0] vec_t;

  vec_t       mask_q, mask_d;
  vec_t       mode_q, mode_d;
  vec_t       pend_q, pend_d;
  vec_t       isr_q, isr_d;
  vec_t       src_q;
  logic       int_q, int_d;
  logic [4:0] id_q, id_d;

  vec_t       wdata;
  logic       wr_mask, wr_mode, wr_clr, wr_set;
  vec_t       edge_set, lvl_set, sw_set, sw_clr;
  vec_t       acc_oh, isr_low, below, elig;
  logic       accept, any_elig;
  logic [4:0] sel;

  assign wdata = cfg_din[NUM_IRQ-1:0];

  generate
    if (NUM_IRQ < 32) begin : g_unused
      logic unused_din;
      assign unused_din = ^cfg_din[31:NUM_IRQ];
    end
  endgenerate

  always_comb begin
    wr_mask = 1'b0;
    wr_mode = 1'b0;
    wr_clr  = 1'b0;
    wr_set  = 1'b0;
    if (cfg_wen) begin
      unique case (cfg_addr)
        2'd0: wr_mask = 1'b1;
        2'd1: wr_mode = 1'b1;
        2'd2: wr_clr  = 1'b1;
        2'd3: wr_set  = 1'b1;
      endcase
    end
  end

  always_comb begin
    cfg_dout = '0;
    unique case (cfg_addr)
      2'd0: cfg_dout = 32'(mask_q);
      2'd1: cfg_dout = 32'(mode_q);
      2'd2: cfg_dout = 32'(pend_q);
      2'd3: cfg_dout = 32'(isr_q);
    endcase
  end

  // Nesting: only channels above the highest-priority in-service one compete.
  assign isr_low = isr_q & (~isr_q + vec_t'(1));
  assign below   = (isr_q == '0) ? '1 : (isr_low - vec_t'(1));
  assign elig    = pend_q & mask_q & below;
  assign any_elig = |elig;

  always_comb begin
    sel = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) sel = 5'(i);
    end
  end

  assign accept   = ir & int_q;
  assign acc_oh   = accept ? (vec_t'(1) << id_q) : '0;
  assign edge_set = irq_src & ~src_q & mode_q;
  assign lvl_set  = irq_src & ~mode_q;
  assign sw_set   = wr_set ? wdata : '0;
  assign sw_clr   = wr_clr ? wdata : '0;

  always_comb begin
    mask_d = wr_mask ? wdata : mask_q;
    mode_d = wr_mode ? wdata : mode_q;
    pend_d = (pend_q & ~(sw_clr | acc_oh))
           | edge_set | lvl_set | sw_set;
    isr_d  = (isr_q & ~(eret ? isr_low : '0)) | acc_oh;
    int_d  = any_elig & ~ir;
    id_d   = any_elig ? sel : id_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= '0;
      mode_q <= '0;
      pend_q <= '0;
      isr_q  <= '0;
      src_q  <= '0;
      int_q  <= 1'b0;
      id_q   <= '0;
    end else begin
      mask_q <= mask_d;
      mode_q <= mode_d;
      pend_q <= pend_d;
      isr_q  <= isr_d;
      src_q  <= irq_src;
      int_q  <= int_d;
      id_q   <= id_d;
    end
  end

  assign interrupt  = int_q;
  assign irq_id     = id_q;
  assign irq_vector = VEC_BASE + (32'(id_q) << VEC_STRIDE_LOG2);

endmodule
